// File: rtl/spi_mem_arbiter_if.sv
// Request/response and SPI pin bundle for spi_mem_arbiter.
// master = requesters + pins side, slave = arbiter side.
interface spi_mem_arbiter_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_data;
  logic        fetch_ready;

  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic [15:0] data_rdata;
  logic        data_ready;

  logic        spi_select;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        busy;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_data,
    input  fetch_ready,
    output data_req,
    output data_we,
    output data_addr,
    output data_wdata,
    input  data_rdata,
    input  data_ready,
    input  spi_select,
    input  spi_clk,
    input  spi_mosi,
    output spi_miso,
    input  busy
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_data,
    output fetch_ready,
    input  data_req,
    input  data_we,
    input  data_addr,
    input  data_wdata,
    output data_rdata,
    output data_ready,
    output spi_select,
    output spi_clk,
    output spi_mosi,
    input  spi_miso,
    output busy
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter in front of one SPI SRAM.
// Each grant runs a full 48-bit 16-bit-word read or write.
module spi_mem_arbiter #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input logic             clk,
  input logic             rst_n,
  spi_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [47:0] sh;
  logic [14:0] rd;
  logic [15:0] rd_nx;
  logic [5:0]  bit_cnt;
  logic        phase;
  logic        win_data;
  logic        wr;
  logic        fair;
  logic [15:0] fetch_q;
  logic [15:0] rdata_q;

  logic        any_req;
  logic        pick_data;
  logic        accept;
  logic        bit_end;
  logic        last_bit;
  logic [7:0]  cmd;
  logic [15:0] addr_sel;
  logic [15:0] wd_sel;

  assign any_req  = bus.fetch_req | bus.data_req;
  assign accept   = (state == IDLE) && any_req;
  assign bit_end  = (state == SHIFT) && phase;
  assign last_bit = bit_end && (bit_cnt == 6'd47);
  assign rd_nx    = {rd, bus.spi_miso};

  // Winner select: data by default, fetch when it lost last contest.
  always_comb begin
    pick_data = 1'b0;
    unique case (1'b1)
      (bus.data_req && !bus.fetch_req): pick_data = 1'b1;
      (bus.data_req && bus.fetch_req):  pick_data = !fair;
      default:                          pick_data = 1'b0;
    endcase
  end

  // Shift-word fields for the winning request; fetch is read-only.
  always_comb begin
    cmd      = CMD_READ;
    addr_sel = bus.fetch_addr;
    wd_sel   = 16'h0000;
    if (pick_data) begin
      addr_sel = bus.data_addr;
      if (bus.data_we) begin
        cmd    = CMD_WRITE;
        wd_sel = bus.data_wdata;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction latch at accept and fairness bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_data <= 1'b0;
      wr       <= 1'b0;
      fair     <= 1'b0;
    end else if (accept) begin
      win_data <= pick_data;
      wr       <= pick_data && bus.data_we;
      if (bus.fetch_req) begin
        fair <= pick_data;
      end
    end
  end

  // Bit timing: two clk cycles per bit, low then high phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= 6'd0;
      phase   <= 1'b0;
    end else if (accept) begin
      bit_cnt <= 6'd0;
      phase   <= 1'b0;
    end else if (state == SHIFT) begin
      phase <= !phase;
      if (phase) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  // Shift out MSB first, sample MISO as the high phase ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh <= '0;
      rd <= '0;
    end else if (accept) begin
      sh <= {cmd, 8'h00, addr_sel, wd_sel};
      rd <= '0;
    end else if (bit_end) begin
      sh <= {sh[46:0], 1'b0};
      rd <= rd_nx[14:0];
    end
  end

  // Read data lands on the winner's port as DONE begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else if (last_bit && !wr) begin
      if (win_data) begin
        rdata_q <= rd_nx;
      end else begin
        fetch_q <= rd_nx;
      end
    end
  end

  // Pin and handshake outputs decoded from registered state.
  always_comb begin
    bus.spi_select  = (state == SHIFT);
    bus.spi_clk     = (state == SHIFT) && phase;
    bus.spi_mosi    = (state == SHIFT) && sh[47];
    bus.busy        = (state != IDLE);
    bus.fetch_ready = (state == DONE) && !win_data;
    bus.data_ready  = (state == DONE) && win_data;
    bus.fetch_data  = fetch_q;
    bus.data_rdata  = rdata_q;
  end

endmodule
